// File: rtl/sram_arb_pkg.sv
// Shared types for the single-port SRAM arbiter: FSM states, grant owner and SRAM command word.
// Define SRAM_ARB_RR_EN at build time for round-robin ties; default is fixed priority (data first).
package sram_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WEN_W  = DATA_W / 8;

  // WAIT_x: an access for requester x was issued on the previous cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  typedef struct packed {
    logic              en;
    logic [WEN_W-1:0]  wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant decision: a lone eligible requester wins; a tie goes to whoever was not granted last.
// Purely combinational, zero latency; grants are one-hot or all-zero.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic   i_inst_elig,
  input  logic   i_data_elig,
  input  owner_t i_last,
  output logic   o_gnt_inst,
  output logic   o_gnt_data
);

  always_comb begin
    o_gnt_inst = 1'b0;
    o_gnt_data = 1'b0;
    if (i_inst_elig && i_data_elig) begin
      if (i_last == OWN_DATA) begin
        o_gnt_inst = 1'b1;
      end else begin
        o_gnt_data = 1'b1;
      end
    end else begin
      o_gnt_inst = i_inst_elig;
      o_gnt_data = i_data_elig;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM between fetch and load/store: access issued in the grant cycle, valid one cycle later.
// Losers stall via *_stall; SRAM_ARB_RR_EN selects round-robin ties, otherwise data wins ties.
module sram_port_arbiter
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_valid,
  output logic              inst_stall,
  input  logic              data_req,
  input  logic [WEN_W-1:0]  data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              data_stall,
  output logic              mem_en,
  output logic [WEN_W-1:0]  mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              w_inst_elig;
  logic              w_data_elig;
  logic              w_gnt_inst;
  logic              w_gnt_data;
  owner_t            w_last;
  mem_cmd_t          w_cmd;

  assign inst_valid = (r_state == WAIT_I);
  assign data_valid = (r_state == WAIT_D);
  assign inst_rdata = inst_valid ? mem_rdata : r_inst_rdata;
  assign data_rdata = data_valid ? mem_rdata : r_data_rdata;
  assign inst_stall = inst_req & ~inst_valid;
  assign data_stall = data_req & ~data_valid;

  // Gating with resetn keeps the SRAM idle while reset is held.
  assign w_inst_elig = resetn & inst_req & ~inst_valid;
  assign w_data_elig = resetn & data_req & ~data_valid;

  sram_arb_pick u_pick (
    .i_inst_elig (w_inst_elig),
    .i_data_elig (w_data_elig),
    .i_last      (w_last),
    .o_gnt_inst  (w_gnt_inst),
    .o_gnt_data  (w_gnt_data)
  );

`ifdef SRAM_ARB_RR_EN
  owner_t r_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= OWN_INST;
    end else if (w_gnt_inst) begin
      r_last <= OWN_INST;
    end else if (w_gnt_data) begin
      r_last <= OWN_DATA;
    end
  end

  assign w_last = r_last;
`else
  // Pinning "last" to inst makes every tie resolve to data.
  assign w_last = OWN_INST;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_cmd       = '0;
    if (w_gnt_inst) begin
      w_state_nxt = WAIT_I;
      w_cmd.en    = 1'b1;
      w_cmd.addr  = inst_addr;
    end else if (w_gnt_data) begin
      w_state_nxt = WAIT_D;
      w_cmd.en    = 1'b1;
      w_cmd.wen   = data_wen;
      w_cmd.addr  = data_addr;
      w_cmd.wdata = data_wdata;
    end
  end

  assign mem_en    = w_cmd.en;
  assign mem_wen   = w_cmd.wen;
  assign mem_addr  = w_cmd.addr;
  assign mem_wdata = w_cmd.wdata;

  // Read data (or write ack data) is captured on the valid cycle and held until the next one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (inst_valid) begin
        r_inst_rdata <= mem_rdata;
      end
      if (data_valid) begin
        r_data_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed arbitration/reset scenarios, then random traffic
// checked by a scoreboard against a word-level memory model (works with or without SRAM_ARB_RR_EN).
module tb_sram_port_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic        inst_stall;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        data_stall;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass = 0;
  bit rnd_on = 1'b0;

  logic [31:0] sram_mem [bit [29:0]];
  logic [31:0] shadow [bit [29:0]];
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_valid(inst_valid), .inst_stall(inst_stall),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_valid(data_valid), .data_stall(data_stall),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input bit [29:0] w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    bit [29:0] w;
    w = a[31:2];
    return shadow.exists(w) ? shadow[w] : init_word(w);
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    bit [29:0] w;
    w = a[31:2];
    return sram_mem.exists(w) ? sram_mem[w] : init_word(w);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    sram_mem[a[31:2]] = v;
    shadow[a[31:2]]   = v;
  endtask

  // Expected-memory update for a store issued by the bench (read-before-write SRAM).
  task automatic model_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    shadow[a[31:2]] = merge_word(shadow_rd(a), wd, be);
  endtask

  // SRAM model: synchronous read of the pre-write word, byte-masked write.
  logic [31:0] sram_old;
  always @(posedge clk) begin
    if (mem_en) begin
      sram_old = sram_rd(mem_addr);
      mem_rdata <= sram_old;
      if (mem_wen != 4'b0) sram_mem[mem_addr[31:2]] = merge_word(sram_old, mem_wdata, mem_wen);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got no/unexpected event, required a matching one", name);
  endtask

  task automatic finish_bench();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
  endtask

  // Scoreboard monitor: pops the expected value whenever a requester sees valid.
  logic [31:0] last_i, last_d;
  bit have_i = 1'b0, have_d = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rnd_on) begin
        if (mem_en) begin
          check("bus_grant_src",
                32'((inst_req && mem_addr == inst_addr && mem_wen == 4'b0 && mem_wdata == 32'b0) ||
                    (data_req && mem_addr == data_addr && mem_wen == data_wen &&
                     mem_wdata == data_wdata)), 32'd1);
        end else begin
          check("bus_idle_zero", 32'(|{mem_wen, mem_addr, mem_wdata}), 32'd0);
        end
        if (inst_valid) begin
          if (iq.size() == 0) fail("inst_valid_unexpected");
          else begin
            last_i = iq.pop_front();
            have_i = 1'b1;
            check("inst_rdata", inst_rdata, last_i);
          end
        end else if (have_i) begin
          check("inst_rdata_hold", inst_rdata, last_i);
        end
        if (data_valid) begin
          if (dq.size() == 0) fail("data_valid_unexpected");
          else begin
            last_d = dq.pop_front();
            have_d = 1'b1;
            check("data_rdata", data_rdata, last_d);
          end
        end else if (have_d) begin
          check("data_rdata_hold", data_rdata, last_d);
        end
      end
    end
  end

  task automatic drive_inst(input int n);
    for (int t = 0; t < n; t++) begin
      logic [31:0] a;
      int cnt;
      bit got;
      a = 32'hBFC0_0000 + 32'($urandom_range(0, 15)) * 32'd4;
      iq.push_back(shadow_rd(a));
      inst_addr = a;
      inst_req  = 1'b1;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 8) begin
        smp();
        got = inst_valid;
        cnt++;
        cyc();
      end
      if (!got) begin
        fail("inst_timeout");
        finish_bench();
      end
      check("inst_latency_le3", 32'(cnt <= 3), 32'd1);
      if ($urandom_range(0, 2) == 0) begin
        inst_req = 1'b0;
        repeat ($urandom_range(1, 3)) cyc();
      end
    end
    inst_req = 1'b0;
  endtask

  task automatic drive_data(input int n);
    for (int t = 0; t < n; t++) begin
      logic [31:0] a, wd, e;
      logic [3:0] be;
      int cnt;
      bit got;
      a  = 32'h8000_0100 + 32'($urandom_range(0, 7)) * 32'd4;
      be = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      e  = shadow_rd(a);
      if (be != 4'b0) model_store(a, be, wd);
      dq.push_back(e);
      data_addr  = a;
      data_wen   = be;
      data_wdata = wd;
      data_req   = 1'b1;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 8) begin
        smp();
        got = data_valid;
        cnt++;
        cyc();
      end
      if (!got) begin
        fail("data_timeout");
        finish_bench();
      end
      check("data_latency", 32'(cnt <= (RR ? 3 : 2)), 32'd1);
      if ($urandom_range(0, 2) == 0) begin
        data_req = 1'b0;
        repeat ($urandom_range(1, 3)) cyc();
      end
    end
    data_req = 1'b0;
  endtask

  initial begin
    #200000;
    fail("watchdog");
    finish_bench();
  end

  initial begin
    bit first_is_inst;
    int n_iv;
    preload(32'hBFC0_0000, 32'h3C08_0001);
    preload(32'hBFC0_0004, 32'h2408_0002);
    preload(32'h8000_0100, 32'h1234_5678);

    // Reset state
    #1 resetn = 1'b0;
    smp();
    check("rst_valids", {30'b0, inst_valid, data_valid}, 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    check("rst_mem_bus", 32'(|{mem_en, mem_wen, mem_addr, mem_wdata}), 32'd0);
    check("rst_stalls", {30'b0, inst_stall, data_stall}, 32'd0);
    cyc();
    resetn = 1'b1;

    // Single fetch
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    smp();
    check("fetch_c0_mem_en", 32'(mem_en), 32'd1);
    check("fetch_c0_mem_wen", 32'(mem_wen), 32'd0);
    check("fetch_c0_mem_addr", mem_addr, 32'hBFC0_0000);
    check("fetch_c0_stall", 32'(inst_stall), 32'd1);
    cyc();
    smp();
    check("fetch_c1_valid", 32'(inst_valid), 32'd1);
    check("fetch_c1_rdata", inst_rdata, 32'h3C08_0001);
    check("fetch_c1_stall", 32'(inst_stall), 32'd0);
    check("fetch_c1_no_regrant", 32'(mem_en), 32'd0);
    cyc();
    inst_req = 1'b0;
    smp();
    check("fetch_c2_valid_pulse", 32'(inst_valid), 32'd0);
    check("fetch_c2_rdata_hold", inst_rdata, 32'h3C08_0001);
    cyc();

    // Simultaneous requests fresh from reset: data first in both modes
    do_reset();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wen = 4'b0; data_addr = 32'h8000_0100;
    smp();
    check("tie_c0_grant_data", mem_addr, 32'h8000_0100);
    cyc();
    smp();
    check("tie_c1_data_valid", 32'(data_valid), 32'd1);
    check("tie_c1_data_rdata", data_rdata, 32'h1234_5678);
    check("tie_c1_grant_inst", mem_addr, 32'hBFC0_0004);
    cyc();
    data_req = 1'b0;
    smp();
    check("tie_c2_inst_valid", 32'(inst_valid), 32'd1);
    check("tie_c2_inst_rdata", inst_rdata, 32'h2408_0002);
    cyc();

    // Store, then a conflict right after a data grant
    inst_req = 1'b0;
    data_req = 1'b1; data_wen = 4'b0011; data_wdata = 32'h0000_BEEF;
    model_store(32'h8000_0100, 4'b0011, 32'h0000_BEEF);
    smp();
    check("store_mem_wen", 32'(mem_wen), 32'h3);
    check("store_mem_wdata", mem_wdata, 32'h0000_BEEF);
    cyc();
    smp();
    check("store_ack_valid", 32'(data_valid), 32'd1);
    check("store_ack_rdata", data_rdata, 32'h1234_5678);
    cyc();
    first_is_inst = RR;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    data_req = 1'b1; data_wen = 4'b0;
    smp();
    check("conf_c0_first", mem_addr, first_is_inst ? 32'hBFC0_0000 : 32'h8000_0100);
    cyc();
    smp();
    check("conf_c1_second", mem_addr, first_is_inst ? 32'h8000_0100 : 32'hBFC0_0000);
    check("conf_c1_valids", {30'b0, inst_valid, data_valid}, first_is_inst ? 32'd2 : 32'd1);
    cyc();
    inst_req = ~first_is_inst;
    data_req = first_is_inst;
    smp();
    check("conf_c2_valids", {30'b0, inst_valid, data_valid}, first_is_inst ? 32'd1 : 32'd2);
    cyc();
    inst_req = 1'b0; data_req = 1'b0;
    smp();
    check("conf_c3_inst_hold", inst_rdata, 32'h3C08_0001);
    check("conf_c3_data_hold", data_rdata, 32'h1234_BEEF);
    cyc();

    // Reset in the WAIT_D cycle abandons the access; held request is reissued
    data_req = 1'b1; data_wen = 4'b0; data_addr = 32'h8000_0100;
    smp();
    check("rstmid_c0_mem_en", 32'(mem_en), 32'd1);
    cyc();
    resetn = 1'b0;
    smp();
    check("rstmid_data_valid", 32'(data_valid), 32'd0);
    check("rstmid_data_rdata", data_rdata, 32'd0);
    check("rstmid_mem_en", 32'(mem_en), 32'd0);
    check("rstmid_data_stall", 32'(data_stall), 32'd1);
    cyc();
    resetn = 1'b1;
    smp();
    check("rstmid_reissue_addr", {31'b0, mem_en} ^ mem_addr, 32'h8000_0101);
    cyc();
    smp();
    check("rstmid_reissue_valid", 32'(data_valid), 32'd1);
    check("rstmid_reissue_rdata", data_rdata, 32'h1234_BEEF);
    cyc();

    // Both held continuously: grants alternate (last grant was data)
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    data_req = 1'b1;
    n_iv = 0;
    for (int k = 0; k < 6; k++) begin
      smp();
      check("alt_grant", mem_addr,
            (first_is_inst ^ k[0]) ? 32'hBFC0_0000 : 32'h8000_0100);
      if (inst_valid) n_iv++;
      cyc();
    end
    check("alt_inst_valid_rate", 32'(n_iv >= 2), 32'd1);
    inst_req = 1'b0; data_req = 1'b0;
    cyc();
    cyc();

    // Random traffic against the scoreboard
    rnd_on = 1'b1;
    fork
      drive_inst(150);
      drive_data(150);
    join
    repeat (4) cyc();
    rnd_on = 1'b0;
    check("inst_queue_drained", 32'(iq.size()), 32'd0);
    check("data_queue_drained", 32'(dq.size()), 32'd0);
    finish_bench();
  end

endmodule
